// File: rtl/spwm_table_reader.sv
// -----------------------------------------------------------------------------
// spwm_table_reader
//   Sinusoidal PWM generator fed by the 2048x32 sine-table RAM. A DDS phase
//   accumulator, stepped once per carrier period, indexes the table. Each
//   fetched amplitude is scaled to a compare value, double-buffered
//   (shadow -> active at the carrier wrap), and compared against the carrier
//   counter to drive the PWM pair.
//
//   Build option: define SPWM_DEADTIME_EN to derive pwm_out / pwm_out_n
//   through a dead-band counter of DEADTIME cycles. When it is undefined,
//   pwm_out_n is simply enable & ~pwm_out.
//
// Ports
//   clk, reset_n     system clock, asynchronous active-low reset
//   enable           run when high, synchronous stop when low
//   sync_clr         synchronous phase-accumulator clear
//   freq_word        phase increment per carrier period
//   carrier_period   carrier length in clk cycles (values below 4 act as 4)
//   ram_address      table address (top 11 phase bits)
//   ram_chipselect   read strobe, one cycle per fetch
//   ram_clken        RAM clock enable, tied high
//   ram_readdata     table data, [15:0] = unsigned amplitude
//   sample           last captured amplitude
//   sample_valid     one-cycle pulse when sample updates
//   pwm_out          PWM output
//   pwm_out_n        complementary PWM output
// -----------------------------------------------------------------------------
module spwm_table_reader #(
  parameter int PHASE_W  = 32,
  parameter int CNT_W    = 16,
  parameter int DEADTIME = 8
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               enable,
  input  logic               sync_clr,
  input  logic [PHASE_W-1:0] freq_word,
  input  logic [CNT_W-1:0]   carrier_period,
  output logic [10:0]        ram_address,
  output logic               ram_chipselect,
  output logic               ram_clken,
  input  logic [31:0]        ram_readdata,
  output logic [15:0]        sample,
  output logic               sample_valid,
  output logic               pwm_out,
  output logic               pwm_out_n
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_WRAP = 2'd1,
    FETCH     = 2'd2,
    CAPTURE   = 2'd3
  } state_e;

  localparam logic [CNT_W-1:0] MIN_PERIOD = CNT_W'(4);
  localparam logic [CNT_W-1:0] ONE        = CNT_W'(1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CNT_W-1:0]   period_q, period_d;
  logic [CNT_W-1:0]   cmp_shadow_q, cmp_shadow_d;
  logic [CNT_W-1:0]   cmp_act_q, cmp_act_d;
  logic [PHASE_W-1:0] phase_q, phase_d;
  logic [10:0]        addr_q, addr_d;
  logic [15:0]        sample_q, sample_d;
  logic               sample_valid_q, sample_valid_d;

  logic [CNT_W-1:0]   period_req;
  logic [15+CNT_W:0]  prod;
  logic               running, start, wrap, fetch, capture;
  logic               unused_rd_hi;

  // Only the low half of the table word carries amplitude.
  assign unused_rd_hi = ^ram_readdata[31:16];

  // The fetch/capture sequence needs 3 cycles after a wrap, so the carrier
  // is never shorter than 4.
  assign period_req = (carrier_period < MIN_PERIOD) ? MIN_PERIOD : carrier_period;

  assign running = enable & (state_q != IDLE);
  assign start   = enable & (state_q == IDLE);
  assign wrap    = running & (cnt_q == period_q - ONE);
  assign fetch   = (state_q == FETCH);
  assign capture = enable & (state_q == CAPTURE);

  // amplitude * period >> 16: full-scale 0xFFFF still lands below the period,
  // so the output can never be stuck high.
  assign prod = {{CNT_W{1'b0}}, ram_readdata[15:0]} * {16'd0, period_q};

  // RAM side: address is driven from the live phase during FETCH and held
  // afterwards so the bus stays quiet between fetches.
  assign ram_address    = fetch ? phase_q[PHASE_W-1 -: 11] : addr_q;
  assign ram_chipselect = fetch;
  assign ram_clken      = 1'b1;
  assign sample         = sample_q;
  assign sample_valid   = sample_valid_q;

  // ---------------------------------------------------------------- FSM
  always_comb begin
    state_d = state_q;
    if (!enable) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:      state_d = FETCH;
        FETCH:     state_d = CAPTURE;
        CAPTURE:   state_d = WAIT_WRAP;
        WAIT_WRAP: if (wrap) state_d = FETCH;
        default:   state_d = IDLE;
      endcase
    end
  end

  // ----------------------------------------------------------- datapath
  always_comb begin
    cnt_d          = '0;
    period_d       = period_q;
    phase_d        = phase_q;
    cmp_shadow_d   = cmp_shadow_q;
    cmp_act_d      = cmp_act_q;
    sample_d       = sample_q;
    sample_valid_d = 1'b0;
    addr_d         = ram_address;

    // Counter sits at 0 in IDLE, so the FETCH cycle after start is count 0.
    if (running && !wrap) cnt_d = cnt_q + ONE;

    // New period length only takes hold at a period boundary.
    if (start || wrap) period_d = period_req;

    // Clear wins over a coincident wrap.
    if (sync_clr)  phase_d = '0;
    else if (wrap) phase_d = phase_q + freq_word;

    // Compare values are flushed on stop so a restart begins with a
    // silent first period.
    if (!enable) begin
      cmp_shadow_d = '0;
      cmp_act_d    = '0;
    end else begin
      if (capture) cmp_shadow_d = prod[16 +: CNT_W];
      if (wrap)    cmp_act_d    = cmp_shadow_q;
    end

    if (capture) begin
      sample_d       = ram_readdata[15:0];
      sample_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      period_q       <= '0;
      phase_q        <= '0;
      cmp_shadow_q   <= '0;
      cmp_act_q      <= '0;
      addr_q         <= '0;
      sample_q       <= '0;
      sample_valid_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      period_q       <= period_d;
      phase_q        <= phase_d;
      cmp_shadow_q   <= cmp_shadow_d;
      cmp_act_q      <= cmp_act_d;
      addr_q         <= addr_d;
      sample_q       <= sample_d;
      sample_valid_q <= sample_valid_d;
    end
  end

  // --------------------------------------------------------- PWM output
`ifdef SPWM_DEADTIME_EN
  localparam int DT_W = (DEADTIME < 2) ? 1 : $clog2(DEADTIME + 1);
  localparam logic [DT_W-1:0] DT_LOAD = DT_W'(DEADTIME);

  logic            raw_q, raw_d;
  logic [DT_W-1:0] dt_q, dt_d;
  logic            pwm_q, pwm_d, pwm_n_q, pwm_n_d;
  logic            quiet;

  assign quiet = ~running;

  // dt reloads on every raw edge (and while stopped) and counts down; a side
  // may only drive once the raw level has been stable for DEADTIME cycles.
  always_comb begin
    raw_d = running & (cnt_q < cmp_act_q);
    if (quiet || (raw_d != raw_q)) dt_d = DT_LOAD;
    else if (dt_q != '0)           dt_d = dt_q - DT_W'(1);
    else                           dt_d = dt_q;
    pwm_d   = ~quiet &  raw_d & (dt_d == '0);
    pwm_n_d = ~quiet & ~raw_d & (dt_d == '0);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      raw_q   <= 1'b0;
      dt_q    <= '0;
      pwm_q   <= 1'b0;
      pwm_n_q <= 1'b0;
    end else begin
      raw_q   <= raw_d;
      dt_q    <= dt_d;
      pwm_q   <= pwm_d;
      pwm_n_q <= pwm_n_d;
    end
  end

  assign pwm_out   = pwm_q;
  assign pwm_out_n = pwm_n_q;
`else
  logic pwm_q, pwm_d;

  assign pwm_d = enable & (cnt_q < cmp_act_q);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) pwm_q <= 1'b0;
    else          pwm_q <= pwm_d;
  end

  assign pwm_out   = pwm_q;
  assign pwm_out_n = enable & ~pwm_q;
`endif

endmodule

// File: doc/spwm_table_reader.md
Name: spwm_table_reader

Overview:
- Sinusoidal PWM generator that sits directly downstream of the 2048x32 on-chip sine-table RAM in the SPWM Qsys system.
- A DDS phase accumulator, advanced once per carrier period, indexes the table.
- Each returned sample is scaled to a duty-cycle compare value, double-buffered, and compared against a carrier counter to drive the PWM outputs.
- Connects to the RAM's 11-bit address, chip-select, clock-enable and 32-bit read-data signals; 1-cycle read latency.

Parameters:
- PHASE_W, 32, phase accumulator width; table address = phase[PHASE_W-1 -: 11].
- CNT_W, 16, carrier counter / period width.
- DEADTIME, 8, dead-band cycles (used only with SPWM_DEADTIME_EN).

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- enable  in  1  run when high; synchronous stop when low.
- sync_clr  in  1  synchronous phase-accumulator clear.
- freq_word  in  PHASE_W  phase increment per carrier period.
- carrier_period  in  CNT_W  carrier length in clk cycles (min 4).
- ram_address  out  11  table address.
- ram_chipselect  out  1  read strobe, high for exactly one cycle per fetch.
- ram_clken  out  1  RAM clock enable, constant 1.
- ram_readdata  in  32  table data; bits [15:0] are an unsigned amplitude.
- sample  out  16  last captured amplitude.
- sample_valid  out  1  one-cycle pulse when sample updates.
- pwm_out  out  1  PWM output.
- pwm_out_n  out  1  complementary PWM output.

Behaviour:
- Reset: all registers 0 and FSM in IDLE. Outputs at reset: ram_address 0, ram_chipselect 0, ram_clken 1, sample 0, sample_valid 0, pwm_out 0, pwm_out_n 0.
- Period latch: period_act = max(carrier_period, 4), latched on entry from IDLE and at each wrap. A mid-period change of carrier_period takes effect at the next wrap.
- Carrier counter cnt:
  - cnt counts 0..period_act-1 while enable is high.
  - wrap = enable & (cnt == period_act-1); on wrap, cnt <= 0.
  - cnt is held at 0 in IDLE.
- At wrap:
  - phase <= phase + freq_word, modulo 2^PHASE_W.
  - cmp_act <= cmp_shadow.
- sync_clr: forces phase <= 0 and takes priority over a simultaneous wrap (phase = 0, not freq_word). Does not affect cnt or the FSM.
- FSM states IDLE, WAIT_WRAP, FETCH, CAPTURE:
  - IDLE: when enable = 1, go to FETCH (initial fetch at the current phase); cnt starts at 0.
  - FETCH (1 cycle): ram_address = phase[top 11 bits], ram_chipselect = 1; go to CAPTURE.
  - CAPTURE (1 cycle): data is valid because the RAM registers its address.
    - sample <= ram_readdata[15:0].
    - cmp_shadow <= (ram_readdata[15:0] * period_act) >> 16, a 32-bit product whose upper 16 bits are kept.
    - sample_valid = 1 in the following cycle.
    - Go to WAIT_WRAP.
  - WAIT_WRAP: on wrap, go to FETCH. ram_address uses the post-update phase, i.e. the fetch is issued the cycle after the wrap.
  - Any state with enable = 0: go to IDLE next cycle.
- Fetch timing: a fetch always completes within 3 cycles of a wrap, hence period_act >= 4. The compare value fetched in period N is applied in period N+1.
- First period after enable: cmp_act = 0 until the first wrap, so pwm_out is low.
- pwm_out: registered; pwm_out <= enable & (cnt < cmp_act), one cycle behind cnt.
  - cmp_act = 0 gives output always low.
  - Maximum duty is (65535*P)>>16 < P, so the output is never stuck high.
- Disable mid-operation:
  - Within 1 cycle: pwm_out = pwm_out_n = 0, cnt = 0, cmp_act = 0, cmp_shadow = 0.
  - phase and sample are retained; re-enable resumes from the retained phase.
- ram_chipselect never asserts outside FETCH. ram_address holds its last value otherwise.

Optional Feature:
- Macro SPWM_DEADTIME_EN.
- Defined:
  - pwm_out and pwm_out_n are derived from the raw comparison through a dead-band counter.
  - After any raw edge, both outputs are 0 for DEADTIME cycles, then the newly active side goes high.
  - A raw pulse shorter than or equal to DEADTIME produces no high on that side.
  - Both outputs are 0 in IDLE.
- Undefined: pwm_out_n = enable & ~pwm_out, with no dead band.

Test Plan:
- Reset then enable with carrier_period = 100, freq_word = 0x00200000, RAM model data = address:
  - ram_address sequence is 0, 1, 2, … with one chipselect pulse per 100 cycles.
  - sample_valid pulses every 100 cycles.
- RAM returns 0x8000, period 100: cmp = 50, and from the second period on pwm_out is high for exactly 50 of 100 cycles.
- Phase wrap: freq_word = 0x40000000 → addresses 0, 512, 1024, 1536, 0, …
- Boundaries and ordering:
  - carrier_period = 2 → period_act = 4 and a fetch completes every period.
  - carrier_period changed mid-period → old length kept until the wrap.
  - sync_clr asserted on the wrap cycle → next address 0.
- enable dropped mid-FETCH:
  - Next cycle: IDLE, pwm_out = pwm_out_n = 0, no further chipselect.
  - Re-enable → fetch from the retained phase.
- With SPWM_DEADTIME_EN, DEADTIME = 8, 50% duty at period 100:
  - Each output is high for 42 cycles per period.
  - Both outputs are low for 8 cycles at each transition; never high simultaneously.
